// File: rtl/key_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan_pkg
//  Description : Shared constants, FSM state type and key-code helpers for
//                the 5x4 matrix keypad scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_scan_pkg;

    localparam int N_ROW  = 5;
    localparam int N_COL  = 4;
    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] KEY_NONE = 5'd0;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } scan_state_t;

    // Key code = row*4 + col + 1, which is simply {row, col} + 1.
    function automatic logic [CODE_W-1:0] key_code(input logic [2:0] row,
                                                    input logic [1:0] col);
        return {row, col} + 5'd1;
    endfunction

    // Lowest pressed row in one column; rows are active-low.
    function automatic logic [CODE_W-1:0] col_code(input logic [N_ROW-1:0] rows_n,
                                                    input logic [1:0]       col);
        logic [CODE_W-1:0] code;
        code = KEY_NONE;
        for (int r = N_ROW - 1; r >= 0; r--) begin
            if (!rows_n[r]) begin
                code = key_code(3'(r), col);
            end
        end
        return code;
    endfunction

    // Combine two candidate codes so that the lowest nonzero code wins.
    function automatic logic [CODE_W-1:0] lowest_code(input logic [CODE_W-1:0] a,
                                                       input logic [CODE_W-1:0] b);
        if (a == KEY_NONE) begin
            return b;
        end
        if (b == KEY_NONE) begin
            return a;
        end
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_row_sync.sv
`default_nettype none
// ============================================================================
//  Module      : key_row_sync
//  Description : Two-flop synchronizer for asynchronous keypad row inputs.
//                Resets to all ones (rows idle high).
//  Revision    : 1.0 - initial release
// ============================================================================
module key_row_sync #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;

    // Two-stage capture of the asynchronous rows into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '1;
            o_sync <= '1;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan
//  Description : 5-row x 4-column keypad scanner. Drives one column low at a
//                time, resolves the lowest pressed key code per full scan and
//                debounces presses/releases over whole scans.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_scan
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_ROW-1:0]  i_row,
    output logic [N_COL-1:0]  o_col,
    output logic              o_key_valid,
    output logic [CODE_W-1:0] o_key_value,
    output logic              o_key_held
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [N_ROW-1:0]  w_rows_sync;
    logic [DIV_W-1:0]  r_div;
    logic              w_tick;
    logic [1:0]        r_col_idx;
    logic [CODE_W-1:0] r_acc;
    logic [CODE_W-1:0] w_col_code;
    logic [CODE_W-1:0] w_acc_next;
    logic [CODE_W-1:0] r_scan_result;
    logic              r_scan_valid;
    scan_state_t       r_state;
    logic [CODE_W-1:0] r_latched;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;

    key_row_sync #(
        .WIDTH (N_ROW)
    ) u_row_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_row),
        .o_sync  (w_rows_sync)
    );

    assign w_tick     = (r_div == DIV_LAST);
    assign w_col_code = col_code(w_rows_sync, r_col_idx);
    // Column 0 opens a new scan, so accumulation restarts there.
    assign w_acc_next = (r_col_idx == 2'd0) ? w_col_code : lowest_code(r_acc, w_col_code);
    assign w_cnt_inc  = (r_cnt == CNT_TARGET) ? r_cnt : r_cnt + CNT_ONE;

    // Column dwell divider; the column moves on one cycle after its sampling tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
            o_col     <= 4'b1110;
        end else if (w_tick) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            o_col     <= ~(4'b0001 << (r_col_idx + 2'd1));
        end else begin
            r_div     <= r_div + DIV_W'(1);
        end
    end

    // Accumulate the lowest key code over a scan and present it after column 3.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc         <= KEY_NONE;
            r_scan_result <= KEY_NONE;
            r_scan_valid  <= 1'b0;
        end else begin
            r_scan_valid <= 1'b0;
            if (w_tick) begin
                r_acc <= w_acc_next;
                if (r_col_idx == 2'd3) begin
                    r_scan_result <= w_acc_next;
                    r_scan_valid  <= 1'b1;
                end
            end
        end
    end

    // Debounce FSM, stepped once per completed scan, with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_latched   <= KEY_NONE;
            r_cnt       <= '0;
            o_key_valid <= 1'b0;
            o_key_value <= KEY_NONE;
            o_key_held  <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            if (r_scan_valid) begin
                case (r_state)
                    IDLE: begin
                        if (r_scan_result != KEY_NONE) begin
                            r_latched <= r_scan_result;
                            if (CNT_TARGET == CNT_ONE) begin
                                r_cnt       <= '0;
                                o_key_valid <= 1'b1;
                                o_key_value <= r_scan_result;
                                o_key_held  <= 1'b1;
                                r_state     <= HELD;
                            end else begin
                                r_cnt   <= CNT_ONE;
                                r_state <= PRESS_CHK;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (r_scan_result == KEY_NONE) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else if (r_scan_result == r_latched) begin
                            if (w_cnt_inc == CNT_TARGET) begin
                                r_cnt       <= '0;
                                o_key_valid <= 1'b1;
                                o_key_value <= r_latched;
                                o_key_held  <= 1'b1;
                                r_state     <= HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            // A different key bounced in: restart on it.
                            r_latched <= r_scan_result;
                            r_cnt     <= CNT_ONE;
                        end
                    end
                    HELD: begin
                        // Any nonzero result, including a rolled-over key, keeps us here.
                        if (r_scan_result == KEY_NONE) begin
                            if (CNT_TARGET == CNT_ONE) begin
                                r_cnt      <= '0;
                                o_key_held <= 1'b0;
                                r_state    <= IDLE;
                            end else begin
                                r_cnt   <= CNT_ONE;
                                r_state <= RELEASE_CHK;
                            end
                        end
                    end
                    RELEASE_CHK: begin
                        if (r_scan_result == KEY_NONE) begin
                            if (w_cnt_inc == CNT_TARGET) begin
                                r_cnt      <= '0;
                                o_key_held <= 1'b0;
                                r_state    <= IDLE;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end
                    end
                    default: begin
                        r_cnt      <= '0;
                        o_key_held <= 1'b0;
                        r_state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
